// File: rtl/tlb_pkg.sv
// Shared TLB definitions: walker state encoding, PTE field positions and the
// default widths used by the walker and simple_tlb.
package tlb_pkg;

  localparam int unsigned TLB_ENTRY_NUM         = 16;
  localparam int unsigned TLB_VPN_WIDTH         = 20;
  localparam int unsigned TLB_PPN_WIDTH         = 20;
  localparam int unsigned TLB_PAGE_OFFSET_WIDTH = 12;
  localparam int unsigned TLB_PTE_WIDTH         = 32;

  // PTE layout: [0]=valid, [1]=leaf, [PPN_LSB +: PPN_WIDTH]=PPN
  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_L       = 1;
  localparam int unsigned PTE_PPN_LSB = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_FILL    = 3'd5,
    S_FAULT   = 3'd6
  } tlb_walk_state_e;

endpackage

// File: rtl/tlb_rr_ptr.sv
// Round-robin victim pointer: counts 0..ENTRY_NUM-1 and wraps, stepping once
// per cycle while i_advance is high.
//   clk, rst_n   clock, asynchronous active-low reset (pointer -> 0)
//   i_advance    step the pointer this cycle
//   o_ptr        current pointer value
module tlb_rr_ptr #(
  parameter int unsigned ENTRY_NUM = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_advance,
  output logic [$clog2(ENTRY_NUM)-1:0] o_ptr
);

  localparam int unsigned PTR_W = $clog2(ENTRY_NUM);

  logic [PTR_W-1:0] r_ptr;

  // Explicit wrap so non-power-of-two entry counts never reach invalid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (r_ptr == PTR_W'(ENTRY_NUM - 1)) r_ptr <= '0;
      else                                r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker feeding the TLB write port. A miss fetches the
// level-1 PTE, then the level-0 PTE, and either fills the round-robin victim
// slot (write_en pulse) or reports a fault pulse.
//   clk, rst_n                 clock, asynchronous active-low reset
//   miss_valid/ready           miss request handshake; miss_vpn, root_ppn sampled on it
//   mem_req_valid/ready/addr   PTE read request, addr = {table_ppn, vpn_idx, 2'b00}
//   mem_resp_valid/data        in-order PTE read data
//   write_en/index/vpn/ppn     one-cycle TLB fill
//   fault                      one-cycle walk failure, write_vpn holds the VPN
//   busy                       walker not idle
module tlb_refill_walker
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRY_NUM         = TLB_ENTRY_NUM,
  parameter int unsigned VPN_WIDTH         = TLB_VPN_WIDTH,
  parameter int unsigned PPN_WIDTH         = TLB_PPN_WIDTH,
  parameter int unsigned PAGE_OFFSET_WIDTH = TLB_PAGE_OFFSET_WIDTH,
  parameter int unsigned PTE_WIDTH         = TLB_PTE_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   miss_valid,
  output logic                                   miss_ready,
  input  logic [VPN_WIDTH-1:0]                   miss_vpn,
  input  logic [PPN_WIDTH-1:0]                   root_ppn,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] mem_req_addr,
  input  logic                                   mem_resp_valid,
  input  logic [PTE_WIDTH-1:0]                   mem_resp_data,
  output logic                                   write_en,
  output logic [$clog2(ENTRY_NUM)-1:0]           write_index,
  output logic [VPN_WIDTH-1:0]                   write_vpn,
  output logic [PPN_WIDTH-1:0]                   write_ppn,
  output logic                                   fault,
  output logic                                   busy
);

  localparam int unsigned HALF = VPN_WIDTH / 2;

  tlb_walk_state_e        r_state;
  tlb_walk_state_e        w_state_nxt;
  logic [VPN_WIDTH-1:0]   r_vpn;
  logic [PPN_WIDTH-1:0]   r_root_ppn;
  logic [PPN_WIDTH-1:0]   r_next_ppn;
  logic [PPN_WIDTH-1:0]   r_leaf_ppn;

  logic                         w_pte_v;
  logic                         w_pte_l;
  logic [PPN_WIDTH-1:0]         w_pte_ppn;
  logic [HALF-1:0]              w_vpn_idx;
  logic [PPN_WIDTH-1:0]         w_table_ppn;
  logic [PAGE_OFFSET_WIDTH-1:0] w_offset;
  logic                         w_advance;
  logic                         w_unused_pte;

  assign w_pte_v   = mem_resp_data[PTE_V];
  assign w_pte_l   = mem_resp_data[PTE_L];
  assign w_pte_ppn = mem_resp_data[PTE_PPN_LSB +: PPN_WIDTH];
  // PTE bits between L and PPN (and above PPN) are not consumed by the walker
  assign w_unused_pte = ^mem_resp_data;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (miss_valid)    w_state_nxt = S_L1_REQ;
      S_L1_REQ:  if (mem_req_ready) w_state_nxt = S_L1_WAIT;
      // superpages (leaf at level 1) are not supported and fault
      S_L1_WAIT: if (mem_resp_valid)
                   w_state_nxt = (w_pte_v && !w_pte_l) ? S_L0_REQ : S_FAULT;
      S_L0_REQ:  if (mem_req_ready) w_state_nxt = S_L0_WAIT;
      S_L0_WAIT: if (mem_resp_valid)
                   w_state_nxt = (w_pte_v && w_pte_l) ? S_FILL : S_FAULT;
      S_FILL:    w_state_nxt = S_IDLE;
      S_FAULT:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- walk context latches ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpn      <= '0;
      r_root_ppn <= '0;
      r_next_ppn <= '0;
      r_leaf_ppn <= '0;
    end else begin
      if (r_state == S_IDLE && miss_valid) begin
        r_vpn      <= miss_vpn;
        r_root_ppn <= root_ppn;
      end
      if (r_state == S_L1_WAIT && mem_resp_valid) r_next_ppn <= w_pte_ppn;
      if (r_state == S_L0_WAIT && mem_resp_valid && w_pte_v && w_pte_l)
        r_leaf_ppn <= w_pte_ppn;
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    write_en      = 1'b0;
    fault         = 1'b0;
    w_vpn_idx     = r_vpn[HALF-1:0];
    w_table_ppn   = r_next_ppn;
    case (r_state)
      S_IDLE:   miss_ready = 1'b1;
      S_L1_REQ: begin
        mem_req_valid = 1'b1;
        w_vpn_idx     = r_vpn[VPN_WIDTH-1 -: HALF];
        w_table_ppn   = r_root_ppn;
      end
      S_L0_REQ: mem_req_valid = 1'b1;
      S_FILL:   write_en = 1'b1;
      S_FAULT:  fault = 1'b1;
      default:  ;
    endcase
  end

  // Offset field is {zero pad, vpn_idx, 2'b00}; built by slice so the pad may be zero-width
  always_comb begin
    w_offset              = '0;
    w_offset[2 +: HALF]   = w_vpn_idx;
  end

  assign mem_req_addr = mem_req_valid ? {w_table_ppn, w_offset} : '0;
  assign busy         = (r_state != S_IDLE);
  assign write_vpn    = r_vpn;
  assign write_ppn    = r_leaf_ppn;
  assign w_advance    = (r_state == S_FILL);

  tlb_rr_ptr #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_rr_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_advance),
    .o_ptr     (write_index)
  );

endmodule
